soc_system_cpu_s0_oci_dct_packer: RTL and testbench

- Producer end of the OCI data-capture-trace (DCT) interface. Packs 2-bit trace atoms from the CPU debug core into 30-bit dct_buffer frames with a 4-bit dct_count.
- Presents frames over a valid/ready handshake to the trace sink, which may be the test bench or the trace memory.
- Also drives the end-of-test drain: test_ending in, test_has_ended out.

---
 rtl/soc_system_cpu_s0_oci_dct_packer.sv | 120 ++++++++++++
 tb/tb_soc_system_cpu_s0_oci_dct_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/soc_system_cpu_s0_oci_dct_packer.sv
// OCI DCT producer: packs 2-bit trace atoms into 30-bit frames behind a valid/ready handshake.
// Define OCI_DCT_LOSSY_EN to drop atoms instead of back-pressuring and count the drops.
module soc_system_cpu_s0_oci_dct_packer #(
  parameter int unsigned ATOM_W = 2,
  parameter int unsigned DEPTH  = 15,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom_data,
  output logic                      atom_ready,
  input  logic                      flush,
  input  logic                      test_ending,
  output logic [DEPTH*ATOM_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      dct_valid,
  input  logic                      dct_ready,
  output logic                      test_has_ended
`ifdef OCI_DCT_LOSSY_EN
  ,
  output logic [7:0]                dct_drop_cnt
`endif
);

  localparam int unsigned BufW = DEPTH * ATOM_W;
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StEnded} state_e;

  state_e            state_q;
  logic [BufW-1:0]   acc_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic              flush_pend_q;

  logic              acc_full;
  logic              out_free;
  logic              accept;
  logic              merge;
  logic              spill;
  logic              flush_req;
  logic              transfer;
  logic [BufW-1:0]   acc_eff;
  logic [CNT_W-1:0]  cnt_eff;
`ifdef OCI_DCT_LOSSY_EN
  logic              drop;
`endif

  always_comb begin
    acc_full = (acc_cnt_q == FullCnt);
    out_free = !dct_valid || dct_ready;
`ifdef OCI_DCT_LOSSY_EN
    atom_ready = (state_q == StRun);
`else
    atom_ready = (state_q == StRun) && (!acc_full || out_free);
`endif
    accept = atom_valid && atom_ready;
    // A full accumulator cannot absorb the atom; it either starts the next frame or is lost.
    merge  = accept && !acc_full;
    spill  = accept && acc_full && out_free;
`ifdef OCI_DCT_LOSSY_EN
    drop   = accept && acc_full && !out_free;
`endif
    acc_eff   = merge ? {acc_q[BufW-ATOM_W-1:0], atom_data} : acc_q;
    cnt_eff   = acc_cnt_q + CNT_W'(merge);
    flush_req = flush || flush_pend_q || (state_q == StDrain);
    transfer  = out_free && (acc_full || (flush_req && (cnt_eff != '0)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      acc_q          <= '0;
      acc_cnt_q      <= '0;
      flush_pend_q   <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      dct_valid      <= 1'b0;
      test_has_ended <= 1'b0;
`ifdef OCI_DCT_LOSSY_EN
      dct_drop_cnt   <= '0;
`endif
    end else begin
      if (transfer) begin
        dct_buffer   <= acc_eff;
        dct_count    <= cnt_eff;
        dct_valid    <= 1'b1;
        acc_q        <= spill ? BufW'(atom_data) : '0;
        acc_cnt_q    <= spill ? CNT_W'(1) : '0;
        flush_pend_q <= 1'b0;
      end else begin
        if (dct_ready) dct_valid <= 1'b0;
        acc_q     <= acc_eff;
        acc_cnt_q <= cnt_eff;
        if (flush && (cnt_eff != '0)) flush_pend_q <= 1'b1;
      end

      unique case (state_q)
        StRun: begin
          if (test_ending) state_q <= StDrain;
        end
        StDrain: begin
          if ((acc_cnt_q == '0) && out_free) begin
            state_q        <= StEnded;
            test_has_ended <= 1'b1;
          end
        end
        StEnded: begin
          test_has_ended <= 1'b1;
        end
        default: state_q <= StRun;
      endcase

`ifdef OCI_DCT_LOSSY_EN
      if (drop && (dct_drop_cnt != 8'hFF)) dct_drop_cnt <= dct_drop_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_soc_system_cpu_s0_oci_dct_packer.sv
// Directed bench for the OCI DCT packer: framing, flush, backpressure and end-of-test drain.
module tb_soc_system_cpu_s0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_has_ended;
`ifdef OCI_DCT_LOSSY_EN
  logic [7:0]  dct_drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  soc_system_cpu_s0_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_has_ended (test_has_ended)
`ifdef OCI_DCT_LOSSY_EN
    ,
    .dct_drop_cnt   (dct_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; atom_valid = 1'b0; atom_data = 2'd0; flush = 1'b0;
    test_ending = 1'b0; dct_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(dct_valid), 32'd0);
    chk("rst_count", 32'(dct_count), 32'd0);
    chk("rst_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_ended", 32'(test_has_ended), 32'd0);
    reset = 1'b0;
    #1 chk("rst_ready", 32'(atom_ready), 32'd1);

    // 1: full frame of 2'b01
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1'b1; atom_data = 2'b01;
      tick();
    end
    atom_valid = 1'b0;
    chk("t1_not_yet", 32'(dct_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(dct_valid), 32'd1);
    chk("t1_count", 32'(dct_count), 32'd15);
    chk("t1_buffer", 32'(dct_buffer), 32'h15555555);
    tick();
    chk("t1_release", 32'(dct_valid), 32'd0);

    // 2: partial frame by flush
    atom_valid = 1'b1;
    atom_data = 2'd3; tick();
    atom_data = 2'd2; tick();
    atom_data = 2'd1; tick();
    atom_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_valid", 32'(dct_valid), 32'd1);
    chk("t2_count", 32'(dct_count), 32'd3);
    chk("t2_buffer", 32'(dct_buffer), 32'h39);
    tick();

    // 3: backpressure
    dct_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      atom_valid = 1'b1; atom_data = (i < 15) ? 2'd2 : 2'd3;
      #1 chk("t3_ready_acc", 32'(atom_ready), 32'd1);
      tick();
    end
    #1 chk("t3_stall", 32'(atom_ready), 32'd0);
    chk("t3_hold_count", 32'(dct_count), 32'd15);
    chk("t3_hold_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    atom_valid = 1'b0;
    tick();
    chk("t3_hold_valid", 32'(dct_valid), 32'd1);
    chk("t3_hold_buffer2", 32'(dct_buffer), 32'h2AAAAAAA);
    dct_ready = 1'b1;
    #1 chk("t3_ready_back", 32'(atom_ready), 32'd1);
    tick();
    chk("t3_f2_valid", 32'(dct_valid), 32'd1);
    chk("t3_f2_buffer", 32'(dct_buffer), 32'h3FFFFFFF);
    chk("t3_f2_count", 32'(dct_count), 32'd15);
    tick();
    chk("t3_release", 32'(dct_valid), 32'd0);

    // 4: flush with same-cycle atom, then flush on empty accumulator
    atom_valid = 1'b1;
    atom_data = 2'd1; tick();
    atom_data = 2'd2; tick();
    atom_data = 2'd3; tick();
    atom_data = 2'd0; tick();
    atom_data = 2'd1; flush = 1'b1; tick();
    atom_valid = 1'b0; flush = 1'b0;
    chk("t4_valid", 32'(dct_valid), 32'd1);
    chk("t4_count", 32'(dct_count), 32'd5);
    chk("t4_buffer", 32'(dct_buffer), 32'h1B1);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_empty_flush", 32'(dct_valid), 32'd0);
    chk("t4_count_kept", 32'(dct_count), 32'd5);
    tick();
    chk("t4_no_pend", 32'(dct_valid), 32'd0);

    // 5: drain
    for (int i = 0; i < 7; i++) begin
      atom_valid = 1'b1; atom_data = 2'd3;
      tick();
    end
    atom_valid = 1'b0; test_ending = 1'b1;
    tick();
    chk("t5_drain_ready", 32'(atom_ready), 32'd0);
    tick();
    chk("t5_valid", 32'(dct_valid), 32'd1);
    chk("t5_count", 32'(dct_count), 32'd7);
    chk("t5_buffer", 32'(dct_buffer), 32'h3FFF);
    chk("t5_not_ended", 32'(test_has_ended), 32'd0);
    tick();
    chk("t5_ended", 32'(test_has_ended), 32'd1);
    chk("t5_released", 32'(dct_valid), 32'd0);
    test_ending = 1'b0; atom_valid = 1'b1;
    tick();
    chk("t5_sticky", 32'(test_has_ended), 32'd1);
    chk("t5_ready_off", 32'(atom_ready), 32'd0);
    atom_valid = 1'b0;

    // 5b: reset in the middle of a drain
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      atom_valid = 1'b1; atom_data = 2'd2;
      tick();
    end
    atom_valid = 1'b0; test_ending = 1'b1;
    tick(); tick();
    chk("t5b_pre_valid", 32'(dct_valid), 32'd1);
    reset = 1'b1; test_ending = 1'b0;
    tick();
    chk("t5b_valid", 32'(dct_valid), 32'd0);
    chk("t5b_count", 32'(dct_count), 32'd0);
    chk("t5b_buffer", 32'(dct_buffer), 32'd0);
    chk("t5b_ended", 32'(test_has_ended), 32'd0);
    chk("t5b_ready", 32'(atom_ready), 32'd1);
    reset = 1'b0;

`ifdef OCI_DCT_LOSSY_EN
    // 6: lossy mode drops atoms when both stages are full
    tick();
    dct_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      atom_valid = 1'b1; atom_data = 2'd1;
      tick();
    end
    atom_valid = 1'b0;
    chk("t6_drops", 32'(dct_drop_cnt), 32'd3);
    chk("t6_count", 32'(dct_count), 32'd15);
    dct_ready = 1'b1;
    tick();
    chk("t6_f2_valid", 32'(dct_valid), 32'd1);
    chk("t6_f2_buffer", 32'(dct_buffer), 32'h15555555);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
